// File: rtl/dfs_ctrl_if.sv
// ============================================================================
// Module      : dfs_ctrl_if
// Description : Load/override inputs and clock-select outputs of dfs_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dfs_ctrl_if #(
  parameter int WIN_LEN = 256
) ();
  localparam int CW = $clog2(WIN_LEN + 1);

  logic          busy;
  logic          force_en;
  logic          force_sel;
  logic          sel;
  logic          switching;
  logic          win_done;
  logic [CW-1:0] act_cnt;

  modport master (
    input  busy, force_en, force_sel,
    output sel, switching, win_done, act_cnt
  );

  modport slave (
    output busy, force_en, force_sel,
    input  sel, switching, win_done, act_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dfs_ctrl.sv
// ============================================================================
// Module      : dfs_ctrl
// Description : Windowed busy-count DFS decision with hysteresis, dwell,
//               settle hold-off and software override of the clock select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfs_ctrl #(
  parameter int WIN_LEN = 256,
  parameter int HI_TH   = 192,
  parameter int LO_TH   = 64,
  parameter int DWELL   = 4,
  parameter int SETTLE  = 16
) (
  input  logic       clk,
  input  logic       rstn,
  dfs_ctrl_if.master dfs_io
);

  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int WW = $clog2(WIN_LEN);
  localparam int DW = $clog2(DWELL + 1);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [WW-1:0] C_WIN_LAST    = WW'(WIN_LEN - 1);
  localparam logic [CW-1:0] C_HI_TH       = CW'(HI_TH);
  localparam logic [CW-1:0] C_LO_TH       = CW'(LO_TH);
  localparam logic [DW-1:0] C_DWELL_LAST  = DW'(DWELL - 1);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_SLOW      = 2'd0,
    S_UP_SETTLE = 2'd1,
    S_FAST      = 2'd2,
    S_DN_SETTLE = 2'd3
  } state_t;

  logic [WW-1:0] win_cnt_q,  win_cnt_d;
  logic [CW-1:0] acc_q,      acc_d;
  logic [CW-1:0] act_cnt_q,  act_cnt_d;
  logic          win_done_q, win_done_d;

  state_t        state_q,    state_d;
  logic [DW-1:0] dwell_q,    dwell_d;
  logic [SW-1:0] settle_q,   settle_d;
  logic          sel_q,      sel_d;
  logic          switching_q, switching_d;

  logic          w_win_last;
  logic [CW-1:0] w_acc_sum;

  assign w_win_last = (win_cnt_q == C_WIN_LAST);
  assign w_acc_sum  = acc_q + CW'(dfs_io.busy);

  // The window free-runs regardless of FSM state or override.
  always_comb begin
    win_cnt_d  = win_cnt_q + WW'(1);
    acc_d      = w_acc_sum;
    act_cnt_d  = act_cnt_q;
    win_done_d = 1'b0;
    if (w_win_last) begin
      win_cnt_d  = '0;
      acc_d      = '0;
      act_cnt_d  = w_acc_sum;
      win_done_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    settle_d = settle_q;
    unique case (state_q)
      S_SLOW: begin
        if (dfs_io.force_en) begin
          dwell_d = '0;
          if (dfs_io.force_sel) begin
            state_d  = S_UP_SETTLE;
            settle_d = '0;
          end
        end else if (win_done_q) begin
          if (act_cnt_q >= C_HI_TH) begin
            if (dwell_q == C_DWELL_LAST) begin
              state_d  = S_UP_SETTLE;
              dwell_d  = '0;
              settle_d = '0;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end else begin
            dwell_d = '0;
          end
        end
      end
      S_FAST: begin
        if (dfs_io.force_en) begin
          dwell_d = '0;
          if (!dfs_io.force_sel) begin
            state_d  = S_DN_SETTLE;
            settle_d = '0;
          end
        end else if (win_done_q) begin
          if (act_cnt_q <= C_LO_TH) begin
            if (dwell_q == C_DWELL_LAST) begin
              state_d  = S_DN_SETTLE;
              dwell_d  = '0;
              settle_d = '0;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end else begin
            dwell_d = '0;
          end
        end
      end
      S_UP_SETTLE, S_DN_SETTLE: begin
        // Votes and override are frozen until the switch finishes its handover.
        dwell_d = '0;
        if (settle_q == C_SETTLE_LAST) begin
          state_d  = (state_q == S_UP_SETTLE) ? S_FAST : S_SLOW;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: begin
        state_d  = S_SLOW;
        dwell_d  = '0;
        settle_d = '0;
      end
    endcase

    sel_d       = (state_d == S_UP_SETTLE) || (state_d == S_FAST);
    switching_d = (state_d == S_UP_SETTLE) || (state_d == S_DN_SETTLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_cnt_q   <= '0;
      acc_q       <= '0;
      act_cnt_q   <= '0;
      win_done_q  <= 1'b0;
      state_q     <= S_SLOW;
      dwell_q     <= '0;
      settle_q    <= '0;
      sel_q       <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      act_cnt_q   <= act_cnt_d;
      win_done_q  <= win_done_d;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      settle_q    <= settle_d;
      sel_q       <= sel_d;
      switching_q <= switching_d;
    end
  end

  assign dfs_io.sel       = sel_q;
  assign dfs_io.switching = switching_q;
  assign dfs_io.win_done  = win_done_q;
  assign dfs_io.act_cnt   = act_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dfs_ctrl.sv
// ============================================================================
// Module      : tb_dfs_ctrl
// Description : Window-vector table, override/reset sequences and random
//               traffic compared against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dfs_ctrl;

  localparam int WIN    = 16;
  localparam int HI     = 12;
  localparam int LO     = 4;
  localparam int DWELL  = 2;
  localparam int SETTLE = 8;
  localparam int CW     = $clog2(WIN + 1);

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  dfs_ctrl_if #(.WIN_LEN(WIN)) bus ();

  dfs_ctrl #(
    .WIN_LEN(WIN), .HI_TH(HI), .LO_TH(LO), .DWELL(DWELL), .SETTLE(SETTLE)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .dfs_io (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: window position/sum, last result, selected source,
  // settle cycles remaining and run length of consecutive qualifying windows.
  int   m_pos, m_sum, m_act, m_left, m_streak;
  logic m_wd, m_sel;

  task automatic model_reset();
    m_pos = 0; m_sum = 0; m_act = 0; m_left = 0; m_streak = 0;
    m_wd = 1'b0; m_sel = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic fe, input logic fs);
    if (m_left > 0) begin
      m_left--;
      m_streak = 0;
    end else if (fe) begin
      m_streak = 0;
      if (fs != m_sel) begin
        m_sel  = fs;
        m_left = SETTLE;
      end
    end else if (m_wd) begin
      if (m_sel ? (m_act <= LO) : (m_act >= HI)) m_streak++;
      else m_streak = 0;
      if (m_streak == DWELL) begin
        m_sel    = ~m_sel;
        m_left   = SETTLE;
        m_streak = 0;
      end
    end
    m_sum += int'(b);
    m_pos++;
    if (m_pos == WIN) begin
      m_act = m_sum;
      m_wd  = 1'b1;
      m_sum = 0;
      m_pos = 0;
    end else begin
      m_wd = 1'b0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic exp_sw;
    exp_sw = (m_left > 0);
    checks++;
    if (bus.sel !== m_sel || bus.switching !== exp_sw || bus.win_done !== m_wd ||
        bus.act_cnt !== CW'(m_act)) begin
      errors++;
      $display("FAIL model_cmp at %0t: got sel=%b sw=%b wd=%b act=%0d expected sel=%b sw=%b wd=%b act=%0d",
               $time, bus.sel, bus.switching, bus.win_done, bus.act_cnt,
               m_sel, exp_sw, m_wd, m_act);
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare 1 time unit later.
  task automatic step(input logic b, input logic fe, input logic fs);
    bus.busy      = b;
    bus.force_en  = fe;
    bus.force_sel = fs;
    @(posedge clk);
    model_step(b, fe, fs);
    #1;
    compare_model();
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_sel"},  32'(bus.sel),       32'd0);
    check({nm, "_sw"},   32'(bus.switching), 32'd0);
    check({nm, "_wd"},   32'(bus.win_done),  32'd0);
    check({nm, "_act"},  32'(bus.act_cnt),   32'd0);
  endtask

  typedef struct {
    int   nbusy;
    int   exp_act;
    logic exp_sel;
  } win_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    win_vec_t tbl[$];
    logic fe, fs;
    int   rem;

    tbl.push_back('{16, 16, 1'b0});
    tbl.push_back('{16, 16, 1'b1});
    tbl.push_back('{ 0,  0, 1'b1});
    tbl.push_back('{ 0,  0, 1'b0});
    for (int i = 0; i < 10; i++) tbl.push_back('{8, 8, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tbl.push_back('{16, 16, 1'b0});
      tbl.push_back('{ 0,  0, 1'b0});
    end
    tbl.push_back('{12, 12, 1'b0});
    tbl.push_back('{12, 12, 1'b1});
    tbl.push_back('{ 5,  5, 1'b1});
    tbl.push_back('{ 4,  4, 1'b1});
    tbl.push_back('{ 4,  4, 1'b0});
    tbl.push_back('{11, 11, 1'b0});
    tbl.push_back('{11, 11, 1'b0});

    rstn          = 1'b0;
    bus.busy      = 1'b0;
    bus.force_en  = 1'b0;
    bus.force_sel = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      bus.busy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_reset_vals("rst_hold");
    end
    rstn = 1'b1;
    model_reset();

    // Window-level vectors: count per window, result, and sel one edge later.
    for (int i = 0; i < tbl.size(); i++) begin
      rem = tbl[i].nbusy;
      for (int c = 0; c < WIN; c++) begin
        logic b;
        b = (rem > 0) && ($urandom_range(0, WIN - 1 - c) < rem);
        if (b) rem--;
        step(b, 1'b0, 1'b0);
        if (c == 0 && i > 0) check("win_sel", 32'(bus.sel), 32'(tbl[i-1].exp_sel));
        if (c == WIN - 1) begin
          check("win_done", 32'(bus.win_done), 32'd1);
          check("win_act", 32'(bus.act_cnt), 32'(tbl[i].exp_act));
        end
      end
    end
    step(1'b0, 1'b0, 1'b0);
    check("win_sel_last", 32'(bus.sel), 32'(tbl[tbl.size()-1].exp_sel));

    // Override to fast, retarget mid-settle: takes effect only after settle.
    step(1'b0, 1'b1, 1'b1);
    check("force_up_sel", 32'(bus.sel), 32'd1);
    check("force_up_sw", 32'(bus.switching), 32'd1);
    for (int k = 1; k < SETTLE; k++) begin
      step(1'($urandom_range(0, 1)), 1'b1, (k >= 3) ? 1'b0 : 1'b1);
      check("settle_sel_hold", 32'(bus.sel), 32'd1);
      check("settle_sw_hold", 32'(bus.switching), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0);
    check("settle_end_sw", 32'(bus.switching), 32'd0);
    check("settle_end_sel", 32'(bus.sel), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("force_dn_sel", 32'(bus.sel), 32'd0);
    check("force_dn_sw", 32'(bus.switching), 32'd1);
    for (int k = 0; k < SETTLE; k++) step(1'b0, 1'b1, 1'b0);
    check("slow_stable_sw", 32'(bus.switching), 32'd0);

    // Asynchronous reset in the third cycle of an up-settle.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("pre_rst_sel", 32'(bus.sel), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_vals("rst_async");
    model_reset();
    bus.force_en  = 1'b0;
    bus.force_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.busy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_reset_vals("rst_mid");
    end
    rstn = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_act", 32'(bus.act_cnt), 32'd0);
    for (int i = 1; i < 2 * WIN; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);

    // Random traffic: per-window busy count, occasional override changes.
    fe  = 1'b0;
    fs  = 1'b0;
    rem = 0;
    for (int i = 0; i < 1200; i++) begin
      logic b;
      if (m_pos == 0) begin
        case ($urandom_range(0, 8))
          0: rem = 0;   1: rem = 2;   2: rem = 4;   3: rem = 5;   4: rem = 8;
          5: rem = 11;  6: rem = 12;  7: rem = 14;  default: rem = 16;
        endcase
      end
      b = (rem > 0) && ($urandom_range(0, WIN - 1 - m_pos) < rem);
      if (b) rem--;
      if ($urandom_range(0, 99) < 2) fe = ~fe;
      if ($urandom_range(0, 99) < 5) fs = 1'($urandom_range(0, 1));
      step(b, fe, fs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
